// File: rtl/tridiag_host_if.sv
// Host-side wrapper for the tridiagonal determinant core: collects a/b/c coefficients,
// launches the core, completes its done/ack handshake and holds the result for the host.
module tridiag_host_if #(
  parameter int N     = 16,
  parameter int WIDTH = 16,
  parameter int IW    = $clog2(N)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_sel,
  input  logic [IW-1:0]            in_idx,
  input  logic [WIDTH-1:0]         in_data,
  output logic [WIDTH*(N-1)-1:0]   a_flat,
  output logic [WIDTH*N-1:0]       b_flat,
  output logic [WIDTH*(N-1)-1:0]   c_flat,
  output logic                     det_start,
  input  logic                     det_done,
  input  logic [2*WIDTH-1:0]       det_in,
  output logic                     det_ack,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*WIDTH-1:0]       out_det,
  output logic                     busy,
  output logic                     err
);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_ACK   = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q [N-1];
  logic [WIDTH-1:0]     a_d [N-1];
  logic [WIDTH-1:0]     b_q [N];
  logic [WIDTH-1:0]     b_d [N];
  logic [WIDTH-1:0]     c_q [N-1];
  logic [WIDTH-1:0]     c_d [N-1];
  logic                 err_q, err_d;
  logic [2*WIDTH-1:0]   out_det_q, out_det_d;
  logic                 wr_s;
  logic                 ac_ok_s;
  logic                 b_ok_s;

  assign wr_s    = in_valid && (state_q == S_LOAD);
  assign ac_ok_s = (int'(in_idx) <= (N - 2));
  assign b_ok_s  = (int'(in_idx) <= (N - 1));

  // Next-state, array update and result capture
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    err_d     = err_q;
    out_det_d = out_det_q;
    case (state_q)
      S_LOAD: begin
        if (wr_s) begin
          case (in_sel)
            2'd0: begin
              if (ac_ok_s) begin
                a_d[in_idx] = in_data;
              end else begin
                err_d = 1'b1;
              end
            end
            2'd1: begin
              if (b_ok_s) begin
                b_d[in_idx] = in_data;
              end else begin
                err_d = 1'b1;
              end
            end
            2'd2: begin
              if (ac_ok_s) begin
                c_d[in_idx] = in_data;
              end else begin
                err_d = 1'b1;
              end
            end
            2'd3: begin
              // Clear is applied before go so a combined command runs on zeros
              if (in_data[1]) begin
                for (int i = 0; i < N - 1; i++) begin
                  a_d[i] = {WIDTH{1'b0}};
                  c_d[i] = {WIDTH{1'b0}};
                end
                for (int i = 0; i < N; i++) begin
                  b_d[i] = {WIDTH{1'b0}};
                end
                err_d = 1'b0;
              end else begin
                err_d = err_q;
              end
              if (in_data[0]) begin
                state_d = S_START;
              end else begin
                state_d = S_LOAD;
              end
            end
            default: state_d = S_LOAD;
          endcase
        end else begin
          state_d = S_LOAD;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (det_done) begin
          out_det_d = det_in;
          state_d   = S_ACK;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_ACK: begin
        if (!det_done) begin
          state_d = S_OUT;
        end else begin
          state_d = S_ACK;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_OUT;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // State, coefficient arrays, sticky error and captured determinant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_LOAD;
      err_q     <= 1'b0;
      out_det_q <= {(2*WIDTH){1'b0}};
      for (int i = 0; i < N - 1; i++) begin
        a_q[i] <= {WIDTH{1'b0}};
        c_q[i] <= {WIDTH{1'b0}};
      end
      for (int i = 0; i < N; i++) begin
        b_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      out_det_q <= out_det_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
    end
  end

  for (genvar g = 0; g < N - 1; g++) begin : g_ac_flat
    assign a_flat[g*WIDTH +: WIDTH] = a_q[g];
    assign c_flat[g*WIDTH +: WIDTH] = c_q[g];
  end

  for (genvar g = 0; g < N; g++) begin : g_b_flat
    assign b_flat[g*WIDTH +: WIDTH] = b_q[g];
  end

  assign in_ready  = (state_q == S_LOAD);
  assign busy      = (state_q != S_LOAD);
  assign det_start = (state_q == S_START);
  assign det_ack   = (state_q == S_ACK);
  assign out_valid = (state_q == S_OUT);
  assign out_det   = out_det_q;
  assign err       = err_q;

endmodule

// File: tb/tb_tridiag_host_if.sv
// Directed bench for tridiag_host_if (N=4, WIDTH=16) with a behavioural stub of the determinant core.
module tb_tridiag_host_if;

  localparam int N = 4;
  localparam int W = 16;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_sel;
  logic [IW-1:0]     in_idx;
  logic [W-1:0]      in_data;
  logic [W*(N-1)-1:0] a_flat;
  logic [W*N-1:0]    b_flat;
  logic [W*(N-1)-1:0] c_flat;
  logic              det_start;
  logic              det_done;
  logic [2*W-1:0]    det_in;
  logic              det_ack;
  logic              out_valid;
  logic              out_ready;
  logic [2*W-1:0]    out_det;
  logic              busy;
  logic              err;

  int errors = 0;
  int checks = 0;

  int          stub_delay;
  int          stub_hold;
  logic [31:0] stub_val;
  int          stub_cnt;
  int          hold_cnt;
  int          stub_st;

  tridiag_host_if #(.N(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_idx(in_idx), .in_data(in_data),
    .a_flat(a_flat), .b_flat(b_flat), .c_flat(c_flat),
    .det_start(det_start), .det_done(det_done), .det_in(det_in), .det_ack(det_ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_det(out_det),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Stub core: det_done rises stub_delay edges after start, drops stub_hold edges into the ack
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_st  <= 0;
      stub_cnt <= 0;
      hold_cnt <= 0;
      det_done <= 1'b0;
      det_in   <= 32'h0;
    end else begin
      case (stub_st)
        0: if (det_start) begin stub_cnt <= stub_delay; stub_st <= 1; end
        1: begin
          if (stub_cnt <= 1) begin
            det_done <= 1'b1;
            det_in   <= stub_val;
            hold_cnt <= stub_hold;
            stub_st  <= 2;
          end else begin
            stub_cnt <= stub_cnt - 1;
          end
        end
        2: begin
          if (det_ack) begin
            if (hold_cnt == 0) begin
              det_done <= 1'b0;
              stub_st  <= 0;
            end else begin
              hold_cnt <= hold_cnt - 1;
            end
          end
        end
        default: stub_st <= 0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [1:0]  idx;
    logic [15:0] data;
    logic [47:0] ea;
    logic [63:0] eb;
    logic [47:0] ec;
    logic        eerr;
  } vec_t;

  vec_t vt[15];

  task automatic write1(input logic [1:0] sel, input logic [1:0] idx, input logic [15:0] data);
    in_valid = 1'b1;
    in_sel   = sel;
    in_idx   = idx;
    in_data  = data;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic apply_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      write1(vt[i].sel, vt[i].idx, vt[i].data);
      chk($sformatf("vec%0d_a", i), {16'h0, a_flat}, {16'h0, vt[i].ea});
      chk($sformatf("vec%0d_b", i), b_flat, vt[i].eb);
      chk($sformatf("vec%0d_c", i), {16'h0, c_flat}, {16'h0, vt[i].ec});
      chk($sformatf("vec%0d_err", i), {63'h0, err}, {63'h0, vt[i].eerr});
    end
  endtask

  // Full run: go, optional write attempt while busy, ack handshake, held result, consume
  task automatic do_run(input logic [31:0] val, input int hold, input bit busy_write);
    int n;
    int ack_cycles;
    stub_val   = val;
    stub_delay = 5;
    stub_hold  = hold;
    write1(2'd3, 2'd0, 16'h0001);
    chk("start_pulse", {63'h0, det_start}, 64'h1);
    chk("start_busy", {62'h0, busy, in_ready}, 64'h2);
    @(posedge clk); #1;
    chk("start_single", {63'h0, det_start}, 64'h0);
    if (busy_write) begin
      in_valid = 1'b1; in_sel = 2'd1; in_idx = 2'd1; in_data = 16'h0005;
      chk("busy_in_ready", {63'h0, in_ready}, 64'h0);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    n = 0;
    while (!det_ack && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ack_seen", {63'h0, det_ack}, 64'h1);
    chk("out_det_at_ack", {32'h0, out_det}, {32'h0, val});
    ack_cycles = 0;
    n = 0;
    while (det_ack && n < 50) begin
      chk("ack_no_valid", {63'h0, out_valid}, 64'h0);
      ack_cycles++;
      @(posedge clk); #1;
      n++;
    end
    chk("ack_cycles", 64'(ack_cycles), 64'(hold + 2));
    chk("out_valid_up", {63'h0, out_valid}, 64'h1);
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("out_hold", {31'h0, out_valid, out_det}, {31'h0, 1'b1, val});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_consumed", {61'h0, out_valid, busy, in_ready}, 64'h1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_idx = 2'd0; in_data = 16'h0; out_ready = 1'b0;
    stub_delay = 5; stub_hold = 0; stub_val = 32'h0;

    vt[0]  = '{2'd1, 2'd0, 16'h0002, 48'h0, 64'h0000_0000_0000_0002, 48'h0, 1'b0};
    vt[1]  = '{2'd1, 2'd1, 16'h0002, 48'h0, 64'h0000_0000_0002_0002, 48'h0, 1'b0};
    vt[2]  = '{2'd1, 2'd2, 16'h0002, 48'h0, 64'h0000_0002_0002_0002, 48'h0, 1'b0};
    vt[3]  = '{2'd1, 2'd3, 16'h0002, 48'h0, 64'h0002_0002_0002_0002, 48'h0, 1'b0};
    vt[4]  = '{2'd0, 2'd0, 16'h0001, 48'h0000_0000_0001, 64'h0002_0002_0002_0002, 48'h0, 1'b0};
    vt[5]  = '{2'd0, 2'd1, 16'h0001, 48'h0000_0001_0001, 64'h0002_0002_0002_0002, 48'h0, 1'b0};
    vt[6]  = '{2'd0, 2'd2, 16'h0001, 48'h0001_0001_0001, 64'h0002_0002_0002_0002, 48'h0, 1'b0};
    vt[7]  = '{2'd2, 2'd0, 16'h0001, 48'h0001_0001_0001, 64'h0002_0002_0002_0002, 48'h0000_0000_0001, 1'b0};
    vt[8]  = '{2'd2, 2'd1, 16'h0001, 48'h0001_0001_0001, 64'h0002_0002_0002_0002, 48'h0000_0001_0001, 1'b0};
    vt[9]  = '{2'd2, 2'd2, 16'h0001, 48'h0001_0001_0001, 64'h0002_0002_0002_0002, 48'h0001_0001_0001, 1'b0};
    vt[10] = '{2'd3, 2'd0, 16'h0000, 48'h0001_0001_0001, 64'h0002_0002_0002_0002, 48'h0001_0001_0001, 1'b0};
    vt[11] = '{2'd0, 2'd3, 16'h0007, 48'h0001_0001_0001, 64'h0002_0002_0002_0002, 48'h0001_0001_0001, 1'b1};
    vt[12] = '{2'd2, 2'd3, 16'h0009, 48'h0001_0001_0001, 64'h0002_0002_0002_0002, 48'h0001_0001_0001, 1'b1};
    vt[13] = '{2'd3, 2'd0, 16'h0002, 48'h0, 64'h0, 48'h0, 1'b0};
    vt[14] = '{2'd1, 2'd0, 16'hFFFF, 48'h0, 64'h0000_0000_0000_FFFF, 48'h0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {58'h0, in_ready, busy, det_start, det_ack, out_valid, err}, 64'h20);
    chk("rst_out_det", {32'h0, out_det}, 64'h0);
    chk("rst_flats", {16'h0, a_flat} | b_flat | {16'h0, c_flat}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_out_ready_ignored", {62'h0, busy, out_valid}, 64'h0);

    apply_vecs(0, 12);
    do_run(32'h0000_0005, 3, 1'b0);

    apply_vecs(13, 14);
    do_run(32'hFFFF_FFFE, 0, 1'b1);
    chk("busy_write_dropped", b_flat, 64'h0000_0000_0000_FFFF);

    // Reset while waiting on the core
    stub_delay = 5; stub_hold = 0; stub_val = 32'h1234_5678;
    write1(2'd3, 2'd0, 16'h0001);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_busy", {63'h0, busy}, 64'h1);
    rst = 1'b1;
    #1;
    chk("midrun_rst_ctrl", {58'h0, in_ready, busy, det_start, det_ack, out_valid, err}, 64'h20);
    chk("midrun_rst_b", b_flat, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    write1(2'd1, 2'd2, 16'h0003);
    chk("post_rst_write", b_flat, 64'h0000_0003_0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
